pio_in_irq: RTL and testbench
=============================

Name: pio_in_irq

Overview:
- Parametrised Avalon-MM input PIO for the HPS lightweight bridge.
- Adds the following over the single-bit direct-read PIO:
  - multi-bit input
  - metastability synchroniser
  - optional per-bit debounce
  - per-bit edge capture with write-1-to-clear
  - maskable level interrupt to the HPS GIC
- Used for push-buttons and switches that select zoom mode and option.

Parameters:
- WIDTH, 4, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (>=2).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the debounced value changes. 0 means bypass.
- EDGE_TYPE, 0, edge that sets capture: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- chipselect  in  1  Avalon slave select
- address  in  2  word address
- read  in  1  Avalon read strobe (no side effects)
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  active-high level interrupt

Behaviour:
- Clock and reset: clock clk; reset reset_n, asynchronous, active-low. Every register in the block is cleared by reset.
- Reset values: readdata=0, irq=0, sync chain=0, debounced=0, prev=0, debounce counters=0, irq_mask=0, edge_capture=0.
- Register map (word address). Unused upper bits read 0; writes to RO locations are ignored.
  - 0 DATA, RO: debounced input value.
  - 1 IRQ_MASK, RW: bits [WIDTH-1:0].
  - 2 EDGE_CAPTURE, R/W1C: writing 1 clears that bit, writing 0 has no effect.
  - 3 RAW, RO: synchroniser output before debounce (diagnostic).
- Read path: readdata is registered every clock from the address mux, gated by chipselect. Read latency is 1 (fixed Avalon read latency 1); readdata is 0 when chipselect=0.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; sync_out is the last stage.
- Debounce:
  - DEBOUNCE_CYCLES=0: debounced follows sync_out combinationally.
  - Otherwise each bit has its own counter of width clog2(DEBOUNCE_CYCLES)+1.
  - When sync_out != debounced, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 on a mismatching cycle, debounced <= sync_out and the counter clears.
  - Any cycle where sync_out == debounced clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge detect:
  - prev <= debounced every clock.
  - The edge term per bit is selected by EDGE_TYPE: rising = debounced & ~prev; falling = ~debounced & prev; any = XOR.
- Edge capture: edge_capture <= (edge_capture & ~clear) | edge, where clear = writedata[WIDTH-1:0] when chipselect & write & address==2.
  - If a clear and a new edge hit the same bit in the same cycle, set wins and the bit stays 1.
- End-to-end latency: in_port stable before clock edge 1 → edge_capture bit set at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- irq = |(edge_capture & irq_mask), driven combinationally from registers, so it asserts in the same cycle the capture bit sets.
  - Changing the mask takes effect in the cycle after the write.
- IRQ_MASK write: irq_mask <= writedata[WIDTH-1:0] on chipselect & write & address==1.
- Reset release with an input held high: debounced starts at 0, so a rising edge is reported. Software clears EDGE_CAPTURE after init; this is the decided behaviour.
- Reset asserted mid-debounce or mid-capture: all state clears immediately; no pending edge survives.

Decomposition:
- Shared package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_RAW=3
  - EDGE_RISING/FALLING/ANY encodings
- One sub-module, pio_in_debounce: a single bit covering synchroniser, debounce counter and edge term. It is instantiated WIDTH times with a generate loop.
- The top level holds the register file, read mux and irq.

Test Plan:
- Defaults (WIDTH=4, SYNC=2, DB=0, rising): drive in_port 0000→0101 before edge 1.
  - EDGE_CAPTURE reads 0x5 from edge 3 on.
  - DATA reads 0x5.
  - irq stays 0 with mask 0.
- Write IRQ_MASK=0x4: irq=1 on the next cycle. Write EDGE_CAPTURE=0x4: bit 2 clears, EDGE_CAPTURE=0x1, irq=0.
- Same-cycle collision: new rising edge on bit 0 in the same cycle as a W1C of 0x1 → EDGE_CAPTURE bit 0 remains 1.
- DEBOUNCE_CYCLES=4:
  - A 3-cycle pulse on bit 1: DATA and EDGE_CAPTURE stay 0.
  - A 4-cycle pulse: DATA bit 1=1, capture sets at edge 7.
- EDGE_TYPE=2: toggle bit 3 high then low with DB=0; clear capture between toggles. Bit 3 is captured on both transitions.
- Assert reset_n low mid-debounce with capture=0xF, mask=0xF, irq=1: all outputs are 0 asynchronously. After release, in_port=0 yields no capture.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the interrupting input PIO: register word addresses
// and edge-select encodings.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MASK = 2'd1,
    ADDR_EDGE = 2'd2,
    ADDR_RAW  = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_term(input int edge_type, input logic cur, input logic prev);
    case (edge_type)
      EDGE_FALLING: edge_term = ~cur & prev;
      EDGE_ANY:     edge_term = cur ^ prev;
      default:      edge_term = cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input channel: metastability synchroniser, optional debounce filter
// and the selected edge term of the filtered value.
module pio_in_debounce
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic sync_out,
  output logic debounced,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign debounced = sync_out;
    end else begin : g_filter
      localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
      logic [CW-1:0] cnt;
      logic          db_q;

      // Any agreeing cycle restarts the count, so only a run of
      // DEBOUNCE_CYCLES consecutive mismatches moves the output.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt  <= '0;
          db_q <= 1'b0;
        end else if (sync_out == db_q) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_q <= sync_out;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign debounced = db_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= debounced;
    end
  end

  assign edge_out = edge_term(EDGE_TYPE, debounced, prev);

endmodule

// File: rtl/pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, optional debounce, W1C edge capture
// and a maskable level interrupt.
module pio_in_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] edge_v;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear;
  logic [31:0]      rd_next;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_inputs;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bit   (in_port[i]),
      .sync_out (raw[i]),
      .debounced(deb[i]),
      .edge_out (edge_v[i])
    );
  end

  assign wr_mask = chipselect & write & (address == ADDR_MASK);
  assign wr_edge = chipselect & write & (address == ADDR_EDGE);
  assign clear   = wr_edge ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as a W1C of that bit keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_mask) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~clear) | edge_v;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = deb;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      ADDR_RAW:  rd_next[WIDTH-1:0] = raw;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= chipselect ? rd_next : '0;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  // Reads have no side effects and upper write bits have no storage.
  assign unused_inputs = &{1'b0, read, writedata};

endmodule

// File: tb/tb_pio_in_irq.sv
// Directed self-checking bench for pio_in_irq: default, debounced and
// any-edge configurations sharing one bus and one reset.
module tb_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        cs0 = 1'b0, cs_db = 1'b0, cs_any = 1'b0;
  logic [3:0]  in0 = '0, in_db = '0, in_any = '0;
  logic [31:0] rd0, rd_db, rd_any;
  logic        irq0, irq_db, irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_in_irq #(.WIDTH(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs0), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0)
  );

  pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut_db (
    .clk(clk), .reset_n(reset_n), .chipselect(cs_db), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(rd_db), .in_port(in_db), .irq(irq_db)
  );

  pio_in_irq #(.WIDTH(4), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .chipselect(cs_any), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(rd_any), .in_port(in_any), .irq(irq_any)
  );

  typedef struct {
    logic        cs;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  inp;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(bit cs, int a, bit wr, int wd, int inp, int rd, bit irq);
    vec_t v;
    v.cs = cs; v.addr = 2'(a); v.wr = wr; v.wd = 32'(wd);
    v.inp = 4'(inp); v.rd = 32'(rd); v.irq = irq;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //           cs a  wr wd   in  rd   irq
    vecs[0]  = mk(1, 2, 0, 0,   5,  0,   0);
    vecs[1]  = mk(1, 2, 0, 0,   5,  0,   0);
    vecs[2]  = mk(1, 2, 0, 0,   5,  0,   0);
    vecs[3]  = mk(1, 2, 0, 0,   5,  5,   0);
    vecs[4]  = mk(1, 0, 0, 0,   5,  5,   0);
    vecs[5]  = mk(1, 3, 0, 0,   5,  5,   0);
    vecs[6]  = mk(1, 1, 1, 4,   5,  0,   1);
    vecs[7]  = mk(1, 1, 0, 0,   5,  4,   1);
    vecs[8]  = mk(1, 2, 1, 4,   5,  5,   0);
    vecs[9]  = mk(1, 2, 0, 0,   5,  1,   0);
    vecs[10] = mk(0, 2, 0, 0,   5,  0,   0);
    vecs[11] = mk(1, 0, 1, 15,  5,  5,   0);
    vecs[12] = mk(1, 3, 1, 15,  5,  5,   0);
    vecs[13] = mk(1, 2, 1, 0,   5,  1,   0);
    vecs[14] = mk(1, 2, 0, 0,   5,  1,   0);
    vecs[15] = mk(1, 0, 0, 0,   4,  5,   0);
    vecs[16] = mk(1, 0, 0, 0,   4,  5,   0);
    vecs[17] = mk(1, 0, 0, 0,   4,  4,   0);
    vecs[18] = mk(1, 0, 0, 0,   5,  4,   0);
    vecs[19] = mk(1, 2, 0, 0,   5,  1,   0);
    vecs[20] = mk(1, 2, 1, 1,   5,  1,   0);
    vecs[21] = mk(1, 2, 0, 0,   5,  1,   0);
    vecs[22] = mk(1, 2, 1, 1,   5,  1,   0);
    vecs[23] = mk(1, 2, 0, 0,   5,  0,   0);

    repeat (3) tick();
    check("reset rd0", rd0, 32'h0);
    check("reset irq0", {31'b0, irq0}, 32'h0);
    check("reset rd_db", rd_db, 32'h0);
    reset_n = 1'b1;

    // Default configuration, one clock per vector.
    for (int i = 0; i < NV; i++) begin
      cs0       = vecs[i].cs;
      address   = vecs[i].addr;
      write     = vecs[i].wr;
      writedata = vecs[i].wd;
      in0       = vecs[i].inp;
      tick();
      check($sformatf("vec%0d rd", i), rd0, vecs[i].rd);
      check($sformatf("vec%0d irq", i), {31'b0, irq0}, {31'b0, vecs[i].irq});
    end
    cs0 = 1'b0; write = 1'b0;

    // Debounce: unmask bit 1, then a rejected 3-cycle and an accepted 4-cycle pulse.
    cs_db = 1'b1; address = 2'd1; write = 1'b1; writedata = 32'h2;
    tick();
    write = 1'b0; address = 2'd0;
    in_db = 4'h2;
    for (int e = 1; e <= 11; e++) begin
      if (e == 4) in_db = 4'h0;
      tick();
      check("db short irq", {31'b0, irq_db}, 32'h0);
      check("db short data", rd_db, 32'h0);
    end
    in_db = 4'h2;
    for (int e = 1; e <= 7; e++) begin
      if (e == 5) in_db = 4'h0;
      tick();
      check($sformatf("db long irq e%0d", e), {31'b0, irq_db}, (e == 7) ? 32'h1 : 32'h0);
      check($sformatf("db long data e%0d", e), rd_db, (e == 7) ? 32'h2 : 32'h0);
    end
    address = 2'd2;
    tick();
    check("db capture", rd_db, 32'h2);

    // Any-edge: bit 3 captured on rise and on fall.
    cs_any = 1'b1; address = 2'd1; write = 1'b1; writedata = 32'h8;
    tick();
    write = 1'b0; address = 2'd2;
    in_any = 4'h8;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("any rise irq e%0d", e), {31'b0, irq_any}, (e == 3) ? 32'h1 : 32'h0);
    end
    write = 1'b1; writedata = 32'h8;
    tick();
    write = 1'b0;
    check("any clear irq", {31'b0, irq_any}, 32'h0);
    in_any = 4'h0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("any fall irq e%0d", e), {31'b0, irq_any}, (e == 3) ? 32'h1 : 32'h0);
    end
    tick();
    check("any capture", rd_any, 32'h8);

    // Asynchronous reset while the debounce filter is mid-count.
    in_db = 4'hF;
    repeat (12) tick();
    address = 2'd1; write = 1'b1; writedata = 32'hF;
    tick();
    write = 1'b0; address = 2'd2;
    tick();
    check("pre-reset capture", rd_db, 32'hF);
    check("pre-reset irq", {31'b0, irq_db}, 32'h1);
    in_db = 4'h0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async reset rd_db", rd_db, 32'h0);
    check("async reset irq_db", {31'b0, irq_db}, 32'h0);
    check("async reset rd_any", rd_any, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("post-reset capture", rd_db, 32'h0);
    end
    address = 2'd1;
    tick();
    check("post-reset mask", rd_db, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
